// File: rtl/systolic_mm_core.sv
// Output-stationary N x N systolic matrix multiplier: serial A/B load, skewed
// feed into a PE grid, row-major drain of C with optional accumulation.
module systolic_mm_core #(
   parameter int unsigned N    = 2,
   parameter int unsigned DW   = 2,
   parameter int unsigned ACCW = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_data,
   input  logic            acc_mode,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ACCW-1:0] out_data,
   output logic            out_last,
   output logic            busy
);

   localparam int unsigned NN = N * N;
   localparam int unsigned CW = $clog2(NN + 3 * N);

   typedef enum logic [1:0] {
      S_LOAD_A,
      S_LOAD_B,
      S_COMPUTE,
      S_DRAIN
   } state_e;

   state_e            state_q;
   logic [CW-1:0]     cnt_q;
   logic              acc_mode_q;
   logic              in_ready_q;
   logic              busy_q;
   logic              out_valid_q;
   logic              out_last_q;
   logic [ACCW-1:0]   out_data_q;

   logic [DW-1:0]     a_mat_q [NN];
   logic [DW-1:0]     b_mat_q [NN];
   logic [DW-1:0]     ah_q    [NN];
   logic [DW-1:0]     bv_q    [NN];
   logic [ACCW-1:0]   acc_q   [NN];

   logic [DW-1:0]     a_feed  [N];
   logic [DW-1:0]     b_feed  [N];
   logic [DW-1:0]     a_in    [NN];
   logic [DW-1:0]     b_in    [NN];
   logic [2*DW-1:0]   prod    [NN];
   logic [ACCW-1:0]   acc_d   [NN];
   int unsigned       step_w;

   logic in_hs;
   logic out_hs;

   assign in_hs     = in_valid & in_ready_q;
   assign out_hs    = out_valid_q & out_ready;
   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;

   // Row i of A enters at step k as A[i][k-i]; column j of B as B[k-j][j].
   always_comb begin
      step_w = 32'(cnt_q);
      for (int unsigned i = 0; i < N; i++) begin
         a_feed[i] = '0;
         b_feed[i] = '0;
         if (state_q == S_COMPUTE && step_w >= i && step_w < i + N) begin
            a_feed[i] = a_mat_q[i * N + (step_w - i)];
            b_feed[i] = b_mat_q[(step_w - i) * N + i];
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
         localparam int unsigned P = gi * N + gj;
         if (gj == 0) begin : g_aedge
            assign a_in[P] = a_feed[gi];
         end else begin : g_ain
            assign a_in[P] = ah_q[P - 1];
         end
         if (gi == 0) begin : g_bedge
            assign b_in[P] = b_feed[gj];
         end else begin : g_bin
            assign b_in[P] = bv_q[P - N];
         end
         assign prod[P]  = a_in[P] * b_in[P];
         assign acc_d[P] = acc_q[P] + ACCW'(prod[P]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_LOAD_A;
         cnt_q       <= '0;
         acc_mode_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         for (int unsigned p = 0; p < NN; p++) begin
            a_mat_q[p] <= '0;
            b_mat_q[p] <= '0;
            ah_q[p]    <= '0;
            bv_q[p]    <= '0;
            acc_q[p]   <= '0;
         end
      end else if (flush) begin
         state_q     <= S_LOAD_A;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         for (int unsigned p = 0; p < NN; p++) begin
            ah_q[p]  <= '0;
            bv_q[p]  <= '0;
            acc_q[p] <= '0;
         end
      end else begin
         case (state_q)
            S_LOAD_A: begin
               if (in_hs) begin
                  a_mat_q[cnt_q] <= in_data;
                  busy_q         <= 1'b1;
                  if (cnt_q == '0) acc_mode_q <= acc_mode;
                  if (cnt_q == CW'(NN - 1)) begin
                     state_q <= S_LOAD_B;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            S_LOAD_B: begin
               if (in_hs) begin
                  b_mat_q[cnt_q] <= in_data;
                  if (cnt_q == CW'(NN - 1)) begin
                     state_q    <= S_COMPUTE;
                     cnt_q      <= '0;
                     in_ready_q <= 1'b0;
                     for (int unsigned p = 0; p < NN; p++) begin
                        ah_q[p] <= '0;
                        bv_q[p] <= '0;
                        if (!acc_mode_q) acc_q[p] <= '0;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            S_COMPUTE: begin
               for (int unsigned p = 0; p < NN; p++) begin
                  acc_q[p] <= acc_d[p];
                  ah_q[p]  <= a_in[p];
                  bv_q[p]  <= b_in[p];
               end
               if (cnt_q == CW'(3 * N - 3)) begin
                  state_q     <= S_DRAIN;
                  cnt_q       <= '0;
                  out_valid_q <= 1'b1;
                  out_last_q  <= (NN == 1);
                  out_data_q  <= acc_d[0];
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DRAIN: begin
               if (out_hs) begin
                  if (cnt_q == CW'(NN - 1)) begin
                     state_q     <= S_LOAD_A;
                     cnt_q       <= '0;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     in_ready_q  <= 1'b1;
                     busy_q      <= 1'b0;
                  end else begin
                     cnt_q      <= cnt_q + 1'b1;
                     out_data_q <= acc_q[cnt_q + 1'b1];
                     out_last_q <= ((cnt_q + 1'b1) == CW'(NN - 1));
                  end
               end
            end
            default: state_q <= S_LOAD_A;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_mm_core.sv
// Randomised self-checking bench for systolic_mm_core (N=2 and N=3 instances)
// against a plain matrix-arithmetic reference.
module tb_systolic_mm_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, flush, acc_mode;
   logic [1:0] in_data;
   logic       iv2, ir2, ov2, or2, ol2, bz2;
   logic [3:0] od2;
   logic       iv3, ir3, ov3, or3, ol3, bz3;
   logic [3:0] od3;

   systolic_mm_core #(.N(2), .DW(2), .ACCW(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_data(in_data),
      .acc_mode(acc_mode), .flush(flush), .out_valid(ov2), .out_ready(or2),
      .out_data(od2), .out_last(ol2), .busy(bz2));

   systolic_mm_core #(.N(3), .DW(2), .ACCW(4)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .in_data(in_data),
      .acc_mode(acc_mode), .flush(flush), .out_valid(ov3), .out_ready(or3),
      .out_data(od3), .out_last(ol3), .busy(bz3));

   int nchk = 0;
   int npass = 0;
   int cm[2][9];

   task automatic chk(input string tag, input int got, input int exp);
      nchk++;
      if (got == exp) npass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int n_of(input int s);
      return (s != 0) ? 3 : 2;
   endfunction

   function automatic bit g_ir(input int s); return (s != 0) ? ir3 : ir2; endfunction
   function automatic bit g_ov(input int s); return (s != 0) ? ov3 : ov2; endfunction
   function automatic bit g_ol(input int s); return (s != 0) ? ol3 : ol2; endfunction
   function automatic bit g_bz(input int s); return (s != 0) ? bz3 : bz2; endfunction
   function automatic int g_od(input int s); return (s != 0) ? int'(od3) : int'(od2); endfunction

   task automatic set_iv(input int s, input bit v);
      if (s != 0) iv3 = v; else iv2 = v;
   endtask

   task automatic set_or(input int s, input bit v);
      if (s != 0) or3 = v; else or2 = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int s = 0; s < 2; s++)
         for (int p = 0; p < 9; p++) cm[s][p] = 0;
   endtask

   task automatic load(input int s, input int a[9], input int b[9], input bit am);
      int n  = n_of(s);
      int nn = n * n;
      int guard;
      for (int e = 0; e < 2 * nn; e++) begin
         in_data  = 2'(e < nn ? a[e] : b[e - nn]);
         acc_mode = (e == 0) ? am : 1'($urandom);
         set_iv(s, 1'b1);
         guard = 0;
         while (!g_ir(s) && guard < 20) begin
            step();
            guard++;
         end
         if (guard >= 20) chk("in_ready_timeout", 0, 1);
         step();
      end
      set_iv(s, 1'b0);
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n; j++) begin
            int sum = 0;
            for (int k = 0; k < n; k++) sum += a[i * n + k] * b[k * n + j];
            cm[s][i * n + j] = ((am ? cm[s][i * n + j] : 0) + sum) % 16;
         end
   endtask

   task automatic drain(input int s, input int stall, input bit randbp, input bit chklat);
      int n   = n_of(s);
      int nn  = n * n;
      int lat = 0;
      int idx = 0;
      int guard = 0;
      int st  = stall;
      bit r;
      chk("in_ready_compute", g_ir(s), 0);
      chk("busy_compute", g_bz(s), 1);
      set_iv(s, 1'b1);
      in_data = 2'($urandom);
      set_or(s, 1'b1);
      while (!g_ov(s) && lat < 40) begin
         step();
         lat++;
         in_data = 2'($urandom);
      end
      set_iv(s, 1'b0);
      chk("out_valid_seen", g_ov(s), 1);
      if (chklat) chk("latency", lat, 3 * n - 2);
      while (idx < nn && guard < 200) begin
         r = (st > 0) ? 1'b0 : (randbp ? ($urandom_range(0, 3) != 0) : 1'b1);
         set_or(s, r);
         chk("out_valid", g_ov(s), 1);
         chk($sformatf("out_data[%0d]", idx), g_od(s), cm[s][idx]);
         chk($sformatf("out_last[%0d]", idx), g_ol(s), (idx == nn - 1) ? 1 : 0);
         step();
         guard++;
         if (r) idx++;
         if (st > 0) st--;
      end
      if (guard >= 200) chk("drain_timeout", 0, 1);
      set_or(s, 1'b0);
      chk("out_valid_after", g_ov(s), 0);
      chk("in_ready_after", g_ir(s), 1);
      chk("busy_after", g_bz(s), 0);
   endtask

   int ta[9], tb[9], t3[9], id3[9], b3[9], ra[9], rb[9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; acc_mode = 1'b0; in_data = '0;
      iv2 = 1'b0; or2 = 1'b0; iv3 = 1'b0; or3 = 1'b0;
      clear_model();
      ta  = '{1, 2, 3, 0, 0, 0, 0, 0, 0};
      tb  = '{2, 1, 1, 3, 0, 0, 0, 0, 0};
      t3  = '{3, 3, 3, 3, 0, 0, 0, 0, 0};
      id3 = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
      b3  = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
      step(); step();
      chk("rst_in_ready", ir2, 1);
      chk("rst_out_valid", ov2, 0);
      chk("rst_out_data", od2, 0);
      chk("rst_out_last", ol2, 0);
      chk("rst_busy", bz2, 0);
      chk("rst_in_ready3", ir3, 1);
      rst_n = 1'b1;
      step();

      load(0, ta, tb, 1'b0); drain(0, 0, 1'b0, 1'b1);
      load(0, ta, tb, 1'b1); drain(0, 0, 1'b0, 1'b1);
      load(0, ta, tb, 1'b0); drain(0, 0, 1'b0, 1'b1);
      load(0, t3, t3, 1'b0); drain(0, 0, 1'b0, 1'b1);
      load(0, ta, tb, 1'b0); drain(0, 5, 1'b0, 1'b1);

      // flush on the edge of the 4th A element
      iv2 = 1'b1;
      for (int e = 0; e < 3; e++) begin
         in_data = 2'(ta[e]);
         step();
      end
      chk("busy_partial", bz2, 1);
      in_data = 2'(ta[3]);
      flush = 1'b1;
      step();
      flush = 1'b0;
      iv2 = 1'b0;
      chk("flush_in_ready", ir2, 1);
      chk("flush_busy", bz2, 0);
      chk("flush_out_valid", ov2, 0);
      clear_model();
      load(0, ta, tb, 1'b1); drain(0, 0, 1'b0, 1'b1);

      // asynchronous reset in the middle of COMPUTE
      load(0, ta, tb, 1'b0);
      step(); step();
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", ov2, 0);
      chk("arst_in_ready", ir2, 1);
      chk("arst_busy", bz2, 0);
      step();
      rst_n = 1'b1;
      clear_model();
      step();
      load(0, ta, tb, 1'b1); drain(0, 0, 1'b0, 1'b1);

      load(1, id3, b3, 1'b0); drain(1, 0, 1'b0, 1'b1);

      for (int job = 0; job < 12; job++) begin
         int s = job % 2;
         for (int p = 0; p < 9; p++) begin
            ra[p] = $urandom_range(0, 3);
            rb[p] = $urandom_range(0, 3);
         end
         load(s, ra, rb, 1'($urandom));
         drain(s, $urandom_range(0, 3), 1'b1, 1'b1);
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
